usart_tx_fifo: RTL and testbench

USART_TX_FIFO -- requirements
Module: usart_tx_fifo

---
 rtl/usart_pkg.sv | 20 ++
 rtl/usart_sync_fifo.sv | 53 +++++
 rtl/usart_tx_fifo.sv | 158 +++++++++++++++
 tb/tb_usart_tx_fifo.sv | 191 +++++++++++++++++++
 4 files changed

// File: rtl/usart_pkg.sv
// Shared constants, FSM encoding and bit-period helper for the USART transmitter.
package usart_pkg;

    localparam int PARITY_NONE = 0;
    localparam int PARITY_ODD  = 1;
    localparam int PARITY_EVEN = 2;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP
    } state_t;

    function automatic int calc_div(input int clk_freq, input int baud_rate);
        return clk_freq / baud_rate;
    endfunction

endpackage

// File: rtl/usart_sync_fifo.sv
// Single-clock FIFO with occupancy count; pushes while full and pops while empty are ignored.
module usart_sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [WIDTH-1:0]         wr_data,
    input  logic                     push,
    input  logic                     pop,
    output logic [WIDTH-1:0]         rd_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_LEVEL = DEPTH[AW:0];

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (level == FULL_LEVEL);
    assign empty   = (level == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign rd_data = mem[rd_ptr];

    // DEPTH is a power of two, so the pointers wrap on natural overflow.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   level <= level + 1'b1;
                2'b01:   level <= level - 1'b1;
                default: level <= level;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= wr_data;
    end

endmodule

// File: rtl/usart_tx_fifo.sv
// FIFO-buffered asynchronous serial transmitter: start, LSB-first data, optional parity, stop bits.
module usart_tx_fifo
    import usart_pkg::*;
#(
    parameter int CLK_FREQ    = 50_000_000,
    parameter int BAUD_RATE   = 115200,
    parameter int DATA_BITS   = 8,
    parameter int PARITY_MODE = 0,
    parameter int STOP_BITS   = 1,
    parameter int FIFO_DEPTH  = 16
) (
    input  logic                          sys_clk,
    input  logic                          sys_rst_n,
    input  logic [DATA_BITS-1:0]          tx_data,
    input  logic                          tx_valid,
    output logic                          tx_ready,
    output logic                          txd,
    output logic                          busy,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

    localparam int DIV   = calc_div(CLK_FREQ, BAUD_RATE);
    localparam int CNT_W = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CNT_W-1:0] BAUD_LAST = CNT_W'(DIV - 1);
    localparam logic [2:0]       DATA_LAST = 3'(DATA_BITS - 1);
    localparam logic [2:0]       STOP_LAST = 3'(STOP_BITS - 1);

    state_t               state;
    state_t               state_next;
    logic [CNT_W-1:0]     baud_cnt;
    logic [CNT_W-1:0]     baud_next;
    logic [2:0]           bit_cnt;
    logic [2:0]           bit_next;
    logic [DATA_BITS-1:0] shift_reg;
    logic [DATA_BITS-1:0] shift_next;
    logic                 par_reg;
    logic                 par_next;
    logic                 load;
    logic                 bit_end;
    logic                 txd_next;

    logic                 push;
    logic                 fifo_full;
    logic                 fifo_empty;
    logic [DATA_BITS-1:0] fifo_rd_data;

    assign tx_ready = !fifo_full;
    assign push     = tx_valid && tx_ready;
    assign bit_end  = (baud_cnt == BAUD_LAST);

    usart_sync_fifo #(
        .WIDTH (DATA_BITS),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (sys_clk),
        .rst_n   (sys_rst_n),
        .wr_data (tx_data),
        .push    (push),
        .pop     (load),
        .rd_data (fifo_rd_data),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .level   (fifo_level)
    );

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state    <= ST_IDLE;
            baud_cnt <= '0;
            bit_cnt  <= '0;
            txd      <= 1'b1;
        end else begin
            state    <= state_next;
            baud_cnt <= baud_next;
            bit_cnt  <= bit_next;
            txd      <= txd_next;
        end
    end

    always_ff @(posedge sys_clk) begin
        shift_reg <= shift_next;
        par_reg   <= par_next;
    end

    always_comb begin
        state_next = state;
        baud_next  = baud_cnt + 1'b1;
        bit_next   = bit_cnt;
        shift_next = shift_reg;
        par_next   = par_reg;
        load       = 1'b0;
        case (state)
            ST_IDLE: begin
                baud_next = '0;
                if (!fifo_empty) begin
                    state_next = ST_START;
                    load       = 1'b1;
                end
            end
            ST_START: begin
                if (bit_end) state_next = ST_DATA;
            end
            ST_DATA: begin
                if (bit_end) begin
                    if (bit_cnt == DATA_LAST) begin
                        state_next = (PARITY_MODE != PARITY_NONE) ? ST_PARITY : ST_STOP;
                    end else begin
                        bit_next   = bit_cnt + 1'b1;
                        baud_next  = '0;
                        shift_next = shift_reg >> 1;
                    end
                end
            end
            ST_PARITY: begin
                if (bit_end) state_next = ST_STOP;
            end
            ST_STOP: begin
                if (bit_end) begin
                    if (bit_cnt == STOP_LAST) begin
                        // Chain straight into the next frame so the line never idles between words.
                        if (!fifo_empty) begin
                            state_next = ST_START;
                            load       = 1'b1;
                        end else begin
                            state_next = ST_IDLE;
                        end
                    end else begin
                        bit_next  = bit_cnt + 1'b1;
                        baud_next = '0;
                    end
                end
            end
            default: state_next = ST_IDLE;
        endcase
        if (state_next != state) begin
            baud_next = '0;
            bit_next  = '0;
        end
        if (load) begin
            shift_next = fifo_rd_data;
            par_next   = ^fifo_rd_data;
        end
    end

    // txd is decoded from the upcoming state so the registered line changes on the same edge as the FSM.
    always_comb begin
        txd_next = 1'b1;
        case (state_next)
            ST_START:  txd_next = 1'b0;
            ST_DATA:   txd_next = shift_next[0];
            ST_PARITY: txd_next = (PARITY_MODE == PARITY_ODD) ? ~par_reg : par_reg;
            default:   txd_next = 1'b1;
        endcase
    end

    assign busy = (state != ST_IDLE) || !fifo_empty;

endmodule

// File: tb/tb_usart_tx_fifo.sv
// Directed bench for usart_tx_fifo: 8N1, 7E2, 7O1 framing, back-to-back frames, full FIFO and reset abort.
module tb_usart_tx_fifo;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic [7:0] d0;  logic v0, r0, t0, b0;  logic [2:0] l0;
    logic [6:0] d1;  logic v1, r1, t1, b1;  logic [4:0] l1;
    logic [6:0] d2;  logic v2, r2, t2, b2;  logic [1:0] l2;

    int total = 0;
    int bad   = 0;

    logic [7:0] rx_q [$];
    logic [7:0] rx_byte;
    logic [7:0] words [6];
    int         k, guard, full_lvl, seen_full;
    logic       acc;

    usart_tx_fifo #(.CLK_FREQ(1_000_000), .BAUD_RATE(100_000), .DATA_BITS(8),
                    .PARITY_MODE(0), .STOP_BITS(1), .FIFO_DEPTH(4)) u0 (
        .sys_clk(clk), .sys_rst_n(rst_n), .tx_data(d0), .tx_valid(v0),
        .tx_ready(r0), .txd(t0), .busy(b0), .fifo_level(l0));

    usart_tx_fifo #(.CLK_FREQ(1_000_000), .BAUD_RATE(100_000), .DATA_BITS(7),
                    .PARITY_MODE(2), .STOP_BITS(2), .FIFO_DEPTH(16)) u1 (
        .sys_clk(clk), .sys_rst_n(rst_n), .tx_data(d1), .tx_valid(v1),
        .tx_ready(r1), .txd(t1), .busy(b1), .fifo_level(l1));

    usart_tx_fifo #(.CLK_FREQ(1_000_000), .BAUD_RATE(100_000), .DATA_BITS(7),
                    .PARITY_MODE(1), .STOP_BITS(1), .FIFO_DEPTH(2)) u2 (
        .sys_clk(clk), .sys_rst_n(rst_n), .tx_data(d2), .tx_valid(v2),
        .tx_ready(r2), .txd(t2), .busy(b2), .fifo_level(l2));

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic txd_of(input int idx);
        case (idx)
            0:       return t0;
            1:       return t1;
            default: return t2;
        endcase
    endfunction

    // Called on a falling edge; the word is taken on the next rising edge.
    task automatic push(input int idx, input logic [7:0] d);
        case (idx)
            0:       begin d0 = d;      v0 = 1'b1; end
            1:       begin d1 = d[6:0]; v1 = 1'b1; end
            default: begin d2 = d[6:0]; v2 = 1'b1; end
        endcase
        @(negedge clk);
        v0 = 1'b0; v1 = 1'b0; v2 = 1'b0;
    endtask

    // bits[i] is line bit i (start first); each must hold for exactly 10 cycles.
    task automatic check_line(input int idx, input logic [15:0] bits, input int n,
                              input int skip, input string tag);
        for (int c = skip; c < n * 10; c++) begin
            @(negedge clk);
            chk(tag, 32'(txd_of(idx)), 32'(bits[c / 10]));
        end
    endtask

    // Mid-bit sampling receiver on the 8N1 line.
    initial forever begin
        @(negedge clk);
        if (rst_n === 1'b1 && t0 === 1'b0) begin
            repeat (4) @(negedge clk);
            for (int i = 0; i < 8; i++) begin
                repeat (10) @(negedge clk);
                rx_byte[i] = t0;
            end
            repeat (10) @(negedge clk);
            rx_q.push_back(rx_byte);
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        d0 = '0; v0 = 1'b0; d1 = '0; v1 = 1'b0; d2 = '0; v2 = 1'b0;
        rst_n = 1'b0;
        words = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};
        repeat (3) @(negedge clk);
        chk("rst_txd",   32'(t0), 1);
        chk("rst_busy",  32'(b0), 0);
        chk("rst_level", 32'(l0), 0);
        chk("rst_ready", 32'(r0), 1);
        chk("rst_txd1",  32'(t1), 1);
        chk("rst_txd2",  32'(t2), 1);
        rst_n = 1'b1;
        @(negedge clk);

        push(0, 8'hA5);
        chk("a5_txd_at_accept", 32'(t0), 1);
        chk("a5_busy", 32'(b0), 1);
        check_line(0, 16'h034A, 10, 0, "frame_a5_8n1");
        @(negedge clk);
        chk("a5_busy_end", 32'(b0), 0);
        chk("a5_txd_idle", 32'(t0), 1);

        push(1, 8'h55);
        check_line(1, 16'h06AA, 11, 0, "frame_55_even");
        @(negedge clk);
        chk("even_busy_end", 32'(b1), 0);

        push(2, 8'h55);
        check_line(2, 16'h03AA, 10, 0, "frame_55_odd");
        @(negedge clk);
        chk("odd_busy_end", 32'(b2), 0);

        push(1, 8'h00);
        push(1, 8'h7F);
        check_line(1, 16'h0600, 11, 1, "b2b_frame_00");
        check_line(1, 16'h07FE, 11, 0, "b2b_frame_7f");
        @(negedge clk);
        chk("b2b_busy_end", 32'(b1), 0);

        rx_q.delete();
        k = 0; guard = 0; full_lvl = 0; seen_full = 0;
        while (k < 6 && guard < 1000) begin
            d0 = words[k];
            v0 = 1'b1;
            acc = r0;
            if (!r0 && seen_full == 0) begin
                seen_full = 1;
                full_lvl  = int'(l0);
            end
            chk("ready_vs_level", 32'(r0), 32'(l0 != 3'd4));
            @(negedge clk);
            if (acc) k++;
            guard++;
        end
        v0 = 1'b0;
        chk("all_pushed", k, 6);
        chk("saw_not_ready", seen_full, 1);
        chk("level_at_full", full_lvl, 4);
        guard = 0;
        while (rx_q.size() < 6 && guard < 1500) begin
            @(negedge clk);
            guard++;
        end
        chk("rx_count", rx_q.size(), 6);
        for (int i = 0; i < rx_q.size() && i < 6; i++)
            chk("rx_word_order", 32'(rx_q[i]), 32'(words[i]));
        repeat (10) @(negedge clk);
        chk("drain_level", 32'(l0), 0);
        chk("drain_busy", 32'(b0), 0);

        push(0, 8'h3C);
        push(0, 8'h01);
        push(0, 8'h02);
        repeat (10) @(negedge clk);
        chk("pre_rst_level", 32'(l0), 2);
        chk("pre_rst_txd",   32'(t0), 0);
        chk("pre_rst_busy",  32'(b0), 1);
        #2 rst_n = 1'b0;
        #1;
        chk("async_rst_txd",   32'(t0), 1);
        chk("async_rst_level", 32'(l0), 0);
        chk("async_rst_ready", 32'(r0), 1);
        chk("async_rst_busy",  32'(b0), 0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int c = 0; c < 150; c++) begin
            @(negedge clk);
            chk("post_rst_txd_idle", 32'(t0), 1);
            chk("post_rst_level", 32'(l0), 0);
        end
        push(0, 8'h81);
        check_line(0, 16'h0302, 10, 0, "post_rst_frame_81");
        @(negedge clk);
        chk("post_rst_busy_end", 32'(b0), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
